// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage core: stall vector, exception/ERET redirect, CP0 commit.
// Optional stall watchdog enabled by defining PIPE_STALL_WDT_EN.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          BLOCK_CYCLES = 2,
    parameter int          WDT_LIMIT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_if,
    input  logic        stall_req_id,
    input  logic        stall_req_ex,
    input  logic        stall_req_mem,
    input  logic        exc_int,
    input  logic        exc_syscall,
    input  logic        exc_break,
    input  logic        exc_eret,
    input  logic        exc_delayslot,
    input  logic [31:0] exc_pc,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        exc_commit,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic        wdt_timeout
);

    typedef enum logic [1:0] {RUN, WAIT_MEM, BLOCK} state_t;
    typedef enum logic [1:0] {EV_INT, EV_SYS, EV_BRK, EV_ERET} ev_t;

    localparam int BW = (BLOCK_CYCLES < 2) ? 1 : $clog2(BLOCK_CYCLES);
    localparam logic [BW-1:0] BLK_LOAD = BW'(BLOCK_CYCLES - 1);

    if (BLOCK_CYCLES < 1 || WDT_LIMIT < 1) begin : g_bad_params
        $error("pipeline_ctrl: BLOCK_CYCLES and WDT_LIMIT must be >= 1");
    end

    state_t        state_reg, state_next;
    logic [BW-1:0] blk_reg, blk_next;
    ev_t           lat_type_reg, lat_type_next;
    logic [31:0]   lat_pc_reg, lat_pc_next;
    logic          lat_ds_reg, lat_ds_next;

    logic [3:0]    req_vec;
    logic [4:0]    stall_base;
    logic          int_ok, in_event;
    ev_t           in_type;
    logic          accept;
    ev_t           acc_type;
    logic [31:0]   acc_pc;
    logic          acc_ds;

    assign req_vec = {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if};

    // Stage i holds when any stage at or below i-1 (deeper in the pipe) requests a hold.
    for (genvar gi = 0; gi < 5; gi++) begin : g_stall
        localparam int LO = (gi == 0) ? 0 : gi - 1;
        assign stall_base[gi] = |req_vec[3:LO];
    end

    assign int_ok   = exc_int && (state_reg != BLOCK);
    assign in_event = int_ok || exc_syscall || exc_break || exc_eret;

    always_comb begin
        in_type = EV_ERET;
        if (int_ok)           in_type = EV_INT;
        else if (exc_syscall) in_type = EV_SYS;
        else if (exc_break)   in_type = EV_BRK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RUN;
            blk_reg      <= '0;
            lat_type_reg <= EV_INT;
            lat_pc_reg   <= '0;
            lat_ds_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            blk_reg      <= blk_next;
            lat_type_reg <= lat_type_next;
            lat_pc_reg   <= lat_pc_next;
            lat_ds_reg   <= lat_ds_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        blk_next      = blk_reg;
        lat_type_next = lat_type_reg;
        lat_pc_next   = lat_pc_reg;
        lat_ds_next   = lat_ds_reg;
        stall         = stall_base;
        flush         = 1'b0;
        flush_pc      = '0;
        exc_commit    = 1'b0;
        exc_code      = '0;
        exc_epc       = '0;
        exc_bd        = 1'b0;
        accept        = 1'b0;
        acc_type      = in_type;
        acc_pc        = exc_pc;
        acc_ds        = exc_delayslot;

        case (state_reg)
            RUN, BLOCK: begin
                if (state_reg == BLOCK) begin
                    if (blk_reg == '0) state_next = RUN;
                    else               blk_next   = blk_reg - 1'b1;
                end
                if (in_event) begin
                    if (stall_req_mem) begin
                        lat_type_next = in_type;
                        lat_pc_next   = exc_pc;
                        lat_ds_next   = exc_delayslot;
                        state_next    = WAIT_MEM;
                        stall         = 5'b11111;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // The latched event is committed once the bus access finishes.
                if (stall_req_mem) begin
                    stall = 5'b11111;
                end else begin
                    accept   = 1'b1;
                    acc_type = lat_type_reg;
                    acc_pc   = lat_pc_reg;
                    acc_ds   = lat_ds_reg;
                end
            end
            default: state_next = RUN;
        endcase

        if (accept) begin
            flush      = 1'b1;
            stall      = '0;
            state_next = BLOCK;
            blk_next   = BLK_LOAD;
            exc_bd     = acc_ds;
            exc_epc    = acc_ds ? (acc_pc - 32'd4) : acc_pc;
            if (acc_type == EV_ERET) begin
                flush_pc = cp0_epc;
            end else begin
                flush_pc   = EXC_VECTOR;
                exc_commit = 1'b1;
                case (acc_type)
                    EV_SYS:  exc_code = 5'h08;
                    EV_BRK:  exc_code = 5'h09;
                    default: exc_code = 5'h00;
                endcase
            end
        end
    end

`ifdef PIPE_STALL_WDT_EN
    logic [15:0] wdt_cnt_reg;
    logic        wdt_timeout_reg;

    // Flag is set on the edge that completes the WDT_LIMIT-th consecutive stalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt_reg     <= '0;
            wdt_timeout_reg <= 1'b0;
        end else begin
            if (flush || !stall[0])         wdt_cnt_reg <= '0;
            else if (wdt_cnt_reg != 16'hFFFF) wdt_cnt_reg <= wdt_cnt_reg + 16'd1;
            if (stall[0] && !flush && (({1'b0, wdt_cnt_reg} + 17'd1) >= 17'(WDT_LIMIT)))
                wdt_timeout_reg <= 1'b1;
        end
    end

    assign wdt_timeout = wdt_timeout_reg;
`else
    assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; expected responses go through a scoreboard queue
// checked by an independent negedge monitor.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_req_if = 0, stall_req_id = 0, stall_req_ex = 0, stall_req_mem = 0;
    logic        exc_int = 0, exc_syscall = 0, exc_break = 0, exc_eret = 0, exc_delayslot = 0;
    logic [31:0] exc_pc = '0, cp0_epc = '0;
    logic [4:0]  stall;
    logic        flush, exc_commit, exc_bd, wdt_timeout;
    logic [31:0] flush_pc, exc_epc;
    logic [4:0]  exc_code;

`ifdef PIPE_STALL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif
    localparam logic [31:0] VEC = 32'hBFC00380;

    pipeline_ctrl #(.EXC_VECTOR(VEC), .BLOCK_CYCLES(2), .WDT_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
        .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
        .exc_int(exc_int), .exc_syscall(exc_syscall), .exc_break(exc_break),
        .exc_eret(exc_eret), .exc_delayslot(exc_delayslot), .exc_pc(exc_pc),
        .cp0_epc(cp0_epc), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .exc_commit(exc_commit), .exc_code(exc_code), .exc_epc(exc_epc),
        .exc_bd(exc_bd), .wdt_timeout(wdt_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  stall;
        logic        flush;
        logic [31:0] fpc;
        logic        commit;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        wdt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, field, act, req);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare it against the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "stall",    {27'd0, stall},      {27'd0, e.stall});
            chk(e.name, "flush",    {31'd0, flush},      {31'd0, e.flush});
            chk(e.name, "flush_pc", flush_pc,            e.fpc);
            chk(e.name, "commit",   {31'd0, exc_commit}, {31'd0, e.commit});
            chk(e.name, "code",     {27'd0, exc_code},   {27'd0, e.code});
            chk(e.name, "epc",      exc_epc,             e.epc);
            chk(e.name, "bd",       {31'd0, exc_bd},     {31'd0, e.bd});
            chk(e.name, "wdt",      {31'd0, wdt_timeout}, {31'd0, e.wdt});
            $display("txn %-12s stall=%b flush=%b fpc=%h commit=%b code=%h epc=%h bd=%b wdt=%b",
                     e.name, stall, flush, flush_pc, exc_commit, exc_code, exc_epc, exc_bd, wdt_timeout);
        end
    end

    // req = {mem,ex,id,if}; exc = {int,syscall,break,eret}
    task automatic step(input logic r, input logic [3:0] req, input logic [3:0] exc, input logic ds,
                        input logic [31:0] pc, input logic [31:0] cpe, input string nm,
                        input logic [4:0] es, input logic ef, input logic [31:0] efpc, input logic ec,
                        input logic [4:0] ecode, input logic [31:0] eepc, input logic ebd, input logic ew);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = req;
        {exc_int, exc_syscall, exc_break, exc_eret} = exc;
        exc_delayslot = ds;
        exc_pc = pc;
        cp0_epc = cpe;
        e.name = nm; e.stall = es; e.flush = ef; e.fpc = efpc; e.commit = ec;
        e.code = ecode; e.epc = eepc; e.bd = ebd; e.wdt = ew;
        q.push_back(e);
    endtask

    task automatic idle(input string nm);
        step(1'b1, 4'b0, 4'b0, 1'b0, 32'h0, 32'h0, nm, 5'b0, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic stl(input logic [3:0] req, input string nm, input logic [4:0] es);
        step(1'b1, req, 4'b0, 1'b0, 32'h0, 32'h0, nm, es, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 4'b0, 4'b0, 1'b0, 32'h0, 32'h0, "reset0", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        step(1'b0, 4'b0, 4'b0, 1'b0, 32'h0, 32'h0, "reset1", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        idle("idle0");

        // Stall vector patterns
        for (int i = 0; i < 3; i++) stl(4'b0100, "ex_stall", 5'b01111);
        idle("ex_done");
        stl(4'b0001, "if_stall", 5'b00011);
        stl(4'b0010, "id_stall", 5'b00111);
        stl(4'b1000, "mem_stall", 5'b11111);
        stl(4'b0101, "if_ex", 5'b01111);
        idle("idle1");

        // Syscall accepted same cycle
        step(1, 4'b0, 4'b0100, 0, 32'h80001000, 32'h0, "syscall", 5'b0, 1, VEC, 1, 5'h08, 32'h80001000, 0, 0);
        idle("blk_a0"); idle("blk_a1");

        // Break while MEM busy; inputs drop after the first cycle
        step(1, 4'b1000, 4'b0010, 1, 32'h80002004, 32'h0, "brk_wait0", 5'b11111, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        for (int i = 1; i < 4; i++)
            step(1, 4'b1000, 4'b0, 0, 32'h0, 32'h0, "brk_wait", 5'b11111, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        step(1, 4'b0, 4'b0, 0, 32'h0, 32'h0, "brk_accept", 5'b0, 1, VEC, 1, 5'h09, 32'h80002000, 1, 0);
        idle("blk_b0"); idle("blk_b1");

        // ERET
        step(1, 4'b0, 4'b0001, 0, 32'h80003000, 32'h80000400, "eret", 5'b0, 1, 32'h80000400, 0, 5'h0, 32'h80003000, 0, 0);
        idle("blk_c0"); idle("blk_c1");

        // Level-held interrupt: accepts at cycles 0 and 3
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || i == 3)
                step(1, 4'b0, 4'b1000, 0, 32'h80004000, 32'h0, "int_acc", 5'b0, 1, VEC, 1, 5'h00, 32'h80004000, 0, 0);
            else
                step(1, 4'b0, 4'b1000, 0, 32'h80004000, 32'h0, "int_masked", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        end
        idle("idle2");

        // Priority
        step(1, 4'b0, 4'b1110, 0, 32'h80000010, 32'h0, "prio_int", 5'b0, 1, VEC, 1, 5'h00, 32'h80000010, 0, 0);
        idle("blk_d0"); idle("blk_d1");
        step(1, 4'b0, 4'b0110, 0, 32'h80000020, 32'h0, "prio_sys", 5'b0, 1, VEC, 1, 5'h08, 32'h80000020, 0, 0);
        idle("blk_e0"); idle("blk_e1");
        step(1, 4'b0, 4'b0011, 0, 32'h80000030, 32'h0, "prio_brk", 5'b0, 1, VEC, 1, 5'h09, 32'h80000030, 0, 0);
        idle("blk_f0"); idle("blk_f1");

        // Syscall during BLOCK is accepted and restarts the block window
        step(1, 4'b0, 4'b1000, 0, 32'h80000040, 32'h0, "blk_int", 5'b0, 1, VEC, 1, 5'h00, 32'h80000040, 0, 0);
        step(1, 4'b0, 4'b1100, 0, 32'h80000044, 32'h0, "blk_sys", 5'b0, 1, VEC, 1, 5'h08, 32'h80000044, 0, 0);
        step(1, 4'b0, 4'b1000, 0, 32'h80000048, 32'h0, "blk_mask0", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        step(1, 4'b0, 4'b1000, 0, 32'h80000048, 32'h0, "blk_mask1", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        step(1, 4'b0, 4'b1000, 0, 32'h8000004C, 32'h0, "blk_int2", 5'b0, 1, VEC, 1, 5'h00, 32'h8000004C, 0, 0);
        stl(4'b0010, "blk_stall", 5'b00111);
        idle("blk_g1"); idle("idle3");

        // EPC wraps below zero for a delay-slot instruction at address 0
        step(1, 4'b0, 4'b0100, 1, 32'h00000000, 32'h0, "epc_wrap", 5'b0, 1, VEC, 1, 5'h08, 32'hFFFFFFFC, 1, 0);
        idle("blk_h0"); idle("blk_h1");

        // Reset during WAIT_MEM drops the latched event
        step(1, 4'b1000, 4'b0100, 0, 32'h80005000, 32'h0, "rw_latch", 5'b11111, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        step(1, 4'b1000, 4'b0, 0, 32'h0, 32'h0, "rw_wait", 5'b11111, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        step(0, 4'b0, 4'b0, 0, 32'h0, 32'h0, "rw_reset", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        idle("rw_noflush"); idle("rw_idle");

        // ERET latched behind a bus access
        step(1, 4'b1000, 4'b0001, 0, 32'h80006000, 32'h80000800, "eret_wait", 5'b11111, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        step(1, 4'b0, 4'b0, 0, 32'h0, 32'h80000800, "eret_acc", 5'b0, 1, 32'h80000800, 0, 5'h0, 32'h80006000, 0, 0);
        idle("blk_i0"); idle("blk_i1");

        // Watchdog: flag visible after the 8th stalled cycle (build-dependent)
        for (int i = 1; i <= 10; i++)
            step(1, 4'b0010, 4'b0, 0, 32'h0, 32'h0, "wdt_stall", 5'b00111, 0, 32'h0, 0, 5'h0, 32'h0, 0,
                 WDT_ON && (i >= 9));
        step(1, 4'b0, 4'b0, 0, 32'h0, 32'h0, "wdt_hold0", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, WDT_ON);
        step(1, 4'b0, 4'b0, 0, 32'h0, 32'h0, "wdt_hold1", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, WDT_ON);
        step(0, 4'b0, 4'b0, 0, 32'h0, 32'h0, "wdt_reset", 5'b0, 0, 32'h0, 0, 5'h0, 32'h0, 0, 0);
        idle("final");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage core. It collects per-stage stall requests and MEM-stage exception/ERET flags, and drives the stall vector consumed by every pipeline register (stall_current_stage = stall[i], stall_next_stage = stall[i+1]). It also drives the global flush and redirect PC, and sends the CP0 commit strobe. Exceptions raised while MEM is waiting on the bus are latched and accepted when the access completes.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC for interrupt/syscall/break
BLOCK_CYCLES, 2, cycles after an accepted flush during which new exc_int is ignored (>=1)
WDT_LIMIT, 1023, consecutive-stall threshold for the optional watchdog (>=1)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
stall_req_if  in  1  IF requests hold
stall_req_id  in  1  ID requests hold (load-use)
stall_req_ex  in  1  EX requests hold (multi-cycle mul/div)
stall_req_mem  in  1  MEM bus access pending
exc_int  in  1  pending interrupt (CP0)
exc_syscall  in  1  syscall_flag from EX/MEM
exc_break  in  1  break_flag from EX/MEM
exc_eret  in  1  eret_flag from EX/MEM
exc_delayslot  in  1  MEM instruction is in a delay slot
exc_pc  in  32  current_pc_addr of MEM instruction
cp0_epc  in  32  current CP0 EPC
stall  out  5  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB
flush  out  1  clear all pipeline registers this cycle
flush_pc  out  32  PC to load when flush=1
exc_commit  out  1  one-cycle strobe: CP0 writes EPC/Cause/BD
exc_code  out  5  Cause.ExcCode for exc_commit
exc_epc  out  32  EPC value for exc_commit
exc_bd  out  1  Cause.BD for exc_commit
wdt_timeout  out  1  sticky stall-watchdog flag

Behaviour:
- States RUN, WAIT_MEM, BLOCK. Reset (rst=0, async): state=RUN, pending latch cleared, block counter=0, wdt counter=0; all outputs 0.
- Stall vector (flush=0): the deepest requesting stage k sets stall[k:0]=1. if->[1:0], id->[2:0], ex->[3:0], mem->[4:0]. No request gives 0.
- Event = exc_syscall|exc_break|exc_eret|(exc_int & state!=BLOCK). Priority: int > syscall > break > eret.
- RUN: event & !stall_req_mem -> accept in the same cycle (combinational), go to BLOCK. Event & stall_req_mem -> latch type, exc_pc and exc_delayslot, go to WAIT_MEM, stall=5'b11111, flush=0.
- WAIT_MEM: stall=5'b11111 while stall_req_mem=1. The latched event is used even if the inputs drop. The first cycle with stall_req_mem=0 accepts the latched event, then go to BLOCK.
- Accept cycle: flush=1 and stall=0 (flush overrides stall).
  - For int/syscall/break: flush_pc=EXC_VECTOR, exc_commit=1, exc_code = 0x00 int / 0x08 syscall / 0x09 break.
  - For ERET: flush_pc=cp0_epc, exc_commit=0.
  - exc_bd=delayslot; exc_epc = delayslot ? pc-32'd4 : pc (mod 2^32).
- flush, exc_commit, flush_pc, exc_code, exc_epc and exc_bd are valid only in the accept cycle; otherwise they are 0.
- BLOCK: lasts BLOCK_CYCLES cycles (counter), then returns to RUN. exc_int is masked. syscall/break/eret are still accepted, which restarts BLOCK. Stall requests pass through normally.
- Exactly one accept per event. A level-held exc_int cannot re-trigger until BLOCK expires.
- An async reset mid-WAIT_MEM drops the latched event.

Optional Feature:
PIPE_STALL_WDT_EN:
- Defined: a 16-bit counter increments each cycle stall[0]=1 and clears when stall[0]=0 or flush=1. When it reaches WDT_LIMIT, wdt_timeout is set to 1 and holds until reset.
- Undefined: no counter exists and wdt_timeout is tied to 0.

Test Plan:
- stall_req_ex=1 for 3 cycles, others 0 -> stall=5'b01111 for 3 cycles, then 5'b00000; flush=0 throughout.
- exc_syscall=1, exc_pc=32'h80001000, delayslot=0, no stalls -> same cycle flush=1, flush_pc=32'hBFC00380, exc_commit=1, exc_code=0x08, exc_epc=32'h80001000, stall=0.
- exc_break with delayslot=1, exc_pc=32'h80002004 while stall_req_mem=1 for 4 cycles -> stall=5'b11111 for 4 cycles, flush=0. Fifth cycle: flush=1, exc_code=0x09, exc_epc=32'h80002000, exc_bd=1.
- exc_eret=1, cp0_epc=32'h80000400 -> flush=1, flush_pc=32'h80000400, exc_commit=0.
- exc_int held high 6 cycles (BLOCK_CYCLES=2) -> accepts at cycle 0 and cycle 3, exc_code=0x00 each time; no flush in cycles 1-2.
- With PIPE_STALL_WDT_EN and WDT_LIMIT=8: stall_req_id held 10 cycles -> wdt_timeout rises after the 8th stalled cycle and stays 1 until rst=0.
